// File: rtl/sreg_dual_shift_if.sv
// Bus bundle for sreg_dual_shift: the shared serial input, the mode select and both chain outputs.
// The master side drives sinp/choice; the slave (the shift block) drives out/sout.
interface sreg_dual_shift_if #(
   parameter int WIDTH = 4
);
   logic             sinp;
   logic             choice;
   logic [WIDTH-1:0] out;
   logic             sout;

   modport master (
      output sinp,
      output choice,
      input  out,
      input  sout
   );

   modport slave (
      input  sinp,
      input  choice,
      output out,
      output sout
   );
endinterface

// File: rtl/sreg_dual_shift.sv
// Two shift chains fed from one serial input: a SISO delay line (sout) and a SIPO deserialiser (out).
// choice picks which chain advances on each edge; each chain has its own async active-low reset.
module sreg_dual_shift #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               resetsi,
   input  logic               resetpo,
   sreg_dual_shift_if.slave   bus
);

   logic [WIDTH-1:0] s_q;
   logic [WIDTH-1:0] s_d;
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_d;

   // Each chain shifts only on a definite select value, so an unknown choice leaves both holding.
   always_comb begin
      s_d   = s_q;
      out_d = out_q;
      if (bus.choice == 1'b0) begin
         s_d = {s_q[WIDTH-2:0], bus.sinp};
      end
      if (bus.choice == 1'b1) begin
         out_d = {out_q[WIDTH-2:0], bus.sinp};
      end
   end

   always_ff @(posedge clk or negedge resetsi) begin
      if (!resetsi) begin
         s_q <= '0;
      end else begin
         s_q <= s_d;
      end
   end

   always_ff @(posedge clk or negedge resetpo) begin
      if (!resetpo) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign bus.out  = out_q;
   assign bus.sout = s_q[WIDTH-1];

endmodule

// File: tb/tb_sreg_dual_shift.sv
// Self-checking bench for sreg_dual_shift: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a queue-based model of the two chains.
module tb_sreg_dual_shift;

   localparam int W = 4;

   typedef struct {
      logic         ri;
      logic         rp;
      logic         ch;
      logic         si;
      logic [W-1:0] eo;
      logic         es;
   } vec_t;

   logic clk = 1'b0;
   logic resetsi;
   logic resetpo;
   int   tests = 0;
   int   fails = 0;
   vec_t vecs[$];

   sreg_dual_shift_if #(.WIDTH(W)) bus ();

   sreg_dual_shift #(.WIDTH(W)) dut (
      .clk     (clk),
      .resetsi (resetsi),
      .resetpo (resetpo),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check_out(input string name, input logic [W-1:0] exp);
      tests++;
      if (bus.out !== exp) begin
         fails++;
         $display("FAIL %s: out=%b expected %b", name, bus.out, exp);
      end
   endtask

   task automatic check_sout(input string name, input logic exp);
      tests++;
      if (bus.sout !== exp) begin
         fails++;
         $display("FAIL %s: sout=%b expected %b", name, bus.sout, exp);
      end
   endtask

   // Drive inputs away from the edge, take one rising edge, then settle before sampling.
   task automatic edge_step(input logic ri, input logic rp, input logic ch, input logic si);
      resetsi    = ri;
      resetpo    = rp;
      bus.choice = ch;
      bus.sinp   = si;
      @(posedge clk);
      #2;
   endtask

   task automatic add(input logic ri, input logic rp, input logic ch, input logic si,
                      input logic [W-1:0] eo, input logic es);
      vec_t v;
      v.ri = ri; v.rp = rp; v.ch = ch; v.si = si; v.eo = eo; v.es = es;
      vecs.push_back(v);
   endtask

   // Reference model: each chain is the window of the last W bits it accepted.
   logic siso_q[$];
   logic sipo_q[$];

   task automatic model_clear_siso();
      siso_q = {};
      for (int i = 0; i < W; i++) siso_q.push_back(1'b0);
   endtask

   task automatic model_clear_sipo();
      sipo_q = {};
      for (int i = 0; i < W; i++) sipo_q.push_back(1'b0);
   endtask

   function automatic logic [W-1:0] model_out();
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = sipo_q[W-1-i];
      return r;
   endfunction

   initial begin
      logic         ri, rp, ch, si;
      logic [W-1:0] exp_o;
      logic         exp_s;

      resetsi    = 1'b0;
      resetpo    = 1'b0;
      bus.choice = 1'b0;
      bus.sinp   = 1'b0;
      #1;
      check_out("powerup_out", '0);
      check_sout("powerup_sout", 1'b0);

      // Power-up reset held for two edges.
      add(0, 0, 0, 0, 4'b0000, 0);
      add(0, 0, 1, 1, 4'b0000, 0);
      // SISO fill and flush, SIPO held in reset.
      add(1, 0, 0, 1, 4'b0000, 0);
      add(1, 0, 0, 1, 4'b0000, 0);
      add(1, 0, 0, 1, 4'b0000, 0);
      add(1, 0, 0, 1, 4'b0000, 1);
      add(1, 0, 0, 0, 4'b0000, 1);
      add(1, 0, 0, 0, 4'b0000, 1);
      add(1, 0, 0, 0, 4'b0000, 1);
      add(1, 0, 0, 0, 4'b0000, 0);
      // SIPO fill and flush, SISO held in reset.
      add(0, 1, 1, 1, 4'b0001, 0);
      add(0, 1, 1, 1, 4'b0011, 0);
      add(0, 1, 1, 1, 4'b0111, 0);
      add(0, 1, 1, 1, 4'b1111, 0);
      add(0, 1, 1, 0, 4'b1110, 0);
      add(0, 1, 1, 0, 4'b1100, 0);
      add(0, 1, 1, 0, 4'b1000, 0);
      add(0, 1, 1, 0, 4'b0000, 0);
      // SISO pattern 1,0,1,1,0 appears on sout after edges 4..8.
      add(1, 0, 0, 1, 4'b0000, 0);
      add(1, 0, 0, 0, 4'b0000, 0);
      add(1, 0, 0, 1, 4'b0000, 0);
      add(1, 0, 0, 1, 4'b0000, 1);
      add(1, 0, 0, 0, 4'b0000, 0);
      add(1, 0, 0, 0, 4'b0000, 1);
      add(1, 0, 0, 0, 4'b0000, 1);
      add(1, 0, 0, 0, 4'b0000, 0);

      foreach (vecs[i]) begin
         edge_step(vecs[i].ri, vecs[i].rp, vecs[i].ch, vecs[i].si);
         $display("[TB] vec %0d ri=%b rp=%b ch=%b si=%b -> out=%b sout=%b", i,
                  vecs[i].ri, vecs[i].rp, vecs[i].ch, vecs[i].si, bus.out, bus.sout);
         check_out($sformatf("vec%0d_out", i), vecs[i].eo);
         check_sout($sformatf("vec%0d_sout", i), vecs[i].es);
      end

      // SIPO hold: load 1010, then five SISO edges with random data leave out untouched.
      edge_step(1, 1, 1, 1);
      edge_step(1, 1, 1, 0);
      edge_step(1, 1, 1, 1);
      edge_step(1, 1, 1, 0);
      check_out("sipo_load", 4'b1010);
      for (int k = 0; k < 5; k++) begin
         edge_step(1, 1, 0, 1'($urandom_range(0, 1)));
         $display("[TB] sipo_hold edge %0d out=%b", k, bus.out);
         check_out($sformatf("sipo_hold%0d", k), 4'b1010);
      end

      // SISO hold: load 1,1,0,1, freeze with choice=1 while SIPO fills, then drain the rest.
      edge_step(1, 1, 0, 1);
      edge_step(1, 1, 0, 1);
      edge_step(1, 1, 0, 0);
      edge_step(1, 1, 0, 1);
      check_sout("siso_load", 1'b1);
      check_out("siso_load_out", 4'b1010);
      for (int k = 0; k < 4; k++) begin
         edge_step(1, 1, 1, 1);
         $display("[TB] siso_hold edge %0d sout=%b out=%b", k, bus.sout, bus.out);
         check_sout($sformatf("siso_hold%0d", k), 1'b1);
      end
      check_out("siso_hold_out", 4'b1111);
      edge_step(1, 1, 0, 0);
      check_sout("siso_drain0", 1'b1);
      edge_step(1, 1, 0, 0);
      check_sout("siso_drain1", 1'b0);
      edge_step(1, 1, 0, 0);
      check_sout("siso_drain2", 1'b1);
      check_out("siso_drain_out", 4'b1111);

      // Mid-cycle reset pulses: only the matching chain clears, without waiting for an edge.
      resetsi = 1'b0;
      #1;
      $display("[TB] resetsi pulse sout=%b out=%b", bus.sout, bus.out);
      check_sout("pulse_si_sout", 1'b0);
      check_out("pulse_si_out", 4'b1111);
      resetsi = 1'b1;
      #1;
      resetpo = 1'b0;
      #1;
      $display("[TB] resetpo pulse sout=%b out=%b", bus.sout, bus.out);
      check_out("pulse_po_out", 4'b0000);
      check_sout("pulse_po_sout", 1'b0);
      resetpo = 1'b1;

      // Reset coincident with a shifting edge wins; the first edge after release shifts.
      edge_step(1, 1, 1, 1);
      check_out("pre_coincide", 4'b0001);
      edge_step(1, 0, 1, 1);
      $display("[TB] reset_vs_edge out=%b", bus.out);
      check_out("reset_vs_edge", 4'b0000);
      edge_step(1, 1, 1, 1);
      $display("[TB] release_shift out=%b", bus.out);
      check_out("release_shift", 4'b0001);

      // Randomized traffic against the window model.
      edge_step(0, 0, 0, 0);
      model_clear_siso();
      model_clear_sipo();
      for (int k = 0; k < 150; k++) begin
         ri = ($urandom_range(0, 15) != 0);
         rp = ($urandom_range(0, 15) != 0);
         ch = 1'($urandom_range(0, 1));
         si = 1'($urandom_range(0, 1));
         edge_step(ri, rp, ch, si);
         if (!ri) begin
            model_clear_siso();
         end else if (ch == 1'b0) begin
            siso_q.push_back(si);
            void'(siso_q.pop_front());
         end
         if (!rp) begin
            model_clear_sipo();
         end else if (ch == 1'b1) begin
            sipo_q.push_back(si);
            void'(sipo_q.pop_front());
         end
         exp_o = model_out();
         exp_s = siso_q[0];
         $display("[TB] rand %0d ri=%b rp=%b ch=%b si=%b -> out=%b sout=%b", k,
                  ri, rp, ch, si, bus.out, bus.sout);
         check_out($sformatf("rand%0d_out", k), exp_o);
         check_sout($sformatf("rand%0d_sout", k), exp_s);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
